// File: rtl/fnd_cntr_axil_pkg.sv
// Shared constants, FSM state types and the byte-strobe merge helper
// for the FND counter AXI4-Lite register slave.
package fnd_cntr_axil_pkg;

  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam int NUM_REGS = 4;

  // Register map (index = addr[3:2])
  localparam int REG_CTRL   = 0;
  localparam int REG_PRESET = 1;
  localparam int REG_CFG    = 2;
  localparam int REG_AUX    = 3;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_ADDR,
    W_HAVE_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

  // Replace only the bytes whose strobe bit is set; keep the rest.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wstrb);
    logic [31:0] merged;
    merged = old_val;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) merged[8*b +: 8] = wdata[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/fnd_cntr_axil_slave.sv
// AXI4-Lite slave holding four 32-bit control registers for the FND
// counter core. Independent write and read channels, one outstanding
// transaction each, always OKAY responses, addresses alias modulo 16.
module fnd_cntr_axil_slave
  import fnd_cntr_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [31:0]                     slv_reg0,
  output logic [31:0]                     slv_reg1,
  output logic [31:0]                     slv_reg2,
  output logic [31:0]                     slv_reg3,
  output logic [3:0]                      reg_wr_pulse
);

  wr_state_e   wr_state_q;
  rd_state_e   rd_state_q;
  logic [1:0]  wr_idx_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] slv_reg_q [NUM_REGS];
  logic [3:0]  pulse_q;
  logic [31:0] rdata_q;

  logic        aw_hs, w_hs, ar_hs;
  logic        commit_en_d;
  logic [1:0]  commit_idx_d;
  logic [31:0] commit_data_d;
  logic [3:0]  commit_strb_d;

  // Protection bits and address bits outside [3:2] carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot,
                         s00_axi_awaddr, s00_axi_araddr};

  // Ready/valid levels decode directly from the state registers.
  assign s00_axi_awready = (wr_state_q == W_IDLE) || (wr_state_q == W_HAVE_DATA);
  assign s00_axi_wready  = (wr_state_q == W_IDLE) || (wr_state_q == W_HAVE_ADDR);
  assign s00_axi_bvalid  = (wr_state_q == W_RESP);
  assign s00_axi_bresp   = RESP_OKAY;
  assign s00_axi_arready = (rd_state_q == R_IDLE);
  assign s00_axi_rvalid  = (rd_state_q == R_DATA);
  assign s00_axi_rresp   = RESP_OKAY;
  assign s00_axi_rdata   = rdata_q;

  assign aw_hs = s00_axi_awvalid && s00_axi_awready;
  assign w_hs  = s00_axi_wvalid  && s00_axi_wready;
  assign ar_hs = s00_axi_arvalid && s00_axi_arready;

  assign slv_reg0     = slv_reg_q[REG_CTRL];
  assign slv_reg1     = slv_reg_q[REG_PRESET];
  assign slv_reg2     = slv_reg_q[REG_CFG];
  assign slv_reg3     = slv_reg_q[REG_AUX];
  assign reg_wr_pulse = pulse_q;

  // Commit selection: pick address/data from the live bus or the latched half.
  always_comb begin
    commit_en_d   = 1'b0;
    commit_idx_d  = s00_axi_awaddr[3:2];
    commit_data_d = s00_axi_wdata;
    commit_strb_d = s00_axi_wstrb;
    case (wr_state_q)
      W_IDLE:      commit_en_d = aw_hs && w_hs;
      W_HAVE_ADDR: begin
        commit_en_d  = w_hs;
        commit_idx_d = wr_idx_q;
      end
      W_HAVE_DATA: begin
        commit_en_d   = aw_hs;
        commit_data_d = wdata_q;
        commit_strb_d = wstrb_q;
      end
      default:     commit_en_d = 1'b0;
    endcase
  end

  // Write channel FSM: collects AW and W in either order, then holds B.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      wr_state_q <= W_IDLE;
      wr_idx_q   <= 2'd0;
      wdata_q    <= 32'd0;
      wstrb_q    <= 4'd0;
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          if (aw_hs && w_hs) begin
            wr_state_q <= W_RESP;
          end else if (aw_hs) begin
            wr_idx_q   <= s00_axi_awaddr[3:2];
            wr_state_q <= W_HAVE_ADDR;
          end else if (w_hs) begin
            wdata_q    <= s00_axi_wdata;
            wstrb_q    <= s00_axi_wstrb;
            wr_state_q <= W_HAVE_DATA;
          end
        end
        W_HAVE_ADDR: if (w_hs) wr_state_q <= W_RESP;
        W_HAVE_DATA: if (aw_hs) wr_state_q <= W_RESP;
        W_RESP:      if (s00_axi_bready) wr_state_q <= W_IDLE;
        default:     wr_state_q <= W_IDLE;
      endcase
    end
  end

  // Register bank update with byte strobes, plus the per-register write pulse.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      for (int i = 0; i < NUM_REGS; i++) slv_reg_q[i] <= 32'd0;
      pulse_q <= 4'd0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit_en_d && (commit_idx_d == 2'(i)))
          slv_reg_q[i] <= apply_wstrb(slv_reg_q[i], commit_data_d, commit_strb_d);
      end
      pulse_q <= commit_en_d ? (4'b0001 << commit_idx_d) : 4'd0;
    end
  end

  // Read channel FSM: captures the pre-commit register value and holds R.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      rd_state_q <= R_IDLE;
      rdata_q    <= 32'd0;
    end else begin
      case (rd_state_q)
        R_IDLE: if (ar_hs) begin
          rdata_q    <= slv_reg_q[s00_axi_araddr[3:2]];
          rd_state_q <= R_DATA;
        end
        R_DATA:  if (s00_axi_rready) rd_state_q <= R_IDLE;
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fnd_cntr_axil_slave.sv
// Directed bench for fnd_cntr_axil_slave with a read-data scoreboard.
module tb_fnd_cntr_axil_slave;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [7:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [31:0] slv_reg0, slv_reg1, slv_reg2, slv_reg3;
  logic [3:0]  reg_wr_pulse;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [4];
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  fnd_cntr_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(8)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(aresetn),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot),
    .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot),
    .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp),
    .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .slv_reg0(slv_reg0), .slv_reg1(slv_reg1), .slv_reg2(slv_reg2), .slv_reg3(slv_reg3),
    .reg_wr_pulse(reg_wr_pulse)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic bhandshake();
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("bvalid_clr", {31'd0, bvalid}, 32'd0);
  endtask

  task automatic pop_rdata(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk(tag, rdata, e);
      chk({tag, "_rresp"}, {30'd0, rresp}, 32'd0);
    end
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    logic aw_done, w_done, aw_f, w_f;
    aw_done = 1'b0; w_done = 1'b0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
      aw_f = awvalid && awready;
      w_f  = wvalid && wready;
      tick();
      if (aw_f) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_f)  begin wvalid  = 1'b0; w_done  = 1'b1; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_accept", {31'd0, aw_done && w_done}, 32'd1);
    model[a[3:2]] = merge(model[a[3:2]], d, s);
    chk("wr_bvalid", {31'd0, bvalid}, 32'd1);
    chk("wr_bresp", {30'd0, bresp}, 32'd0);
    chk("wr_pulse", {28'd0, reg_wr_pulse}, 32'd1 << a[3:2]);
    bhandshake();
    chk("pulse_clr", {28'd0, reg_wr_pulse}, 32'd0);
  endtask

  task automatic axi_read(input logic [7:0] a);
    exp_q.push_back(model[a[3:2]]);
    araddr = a; arvalid = 1'b1;
    for (int n = 0; n < 20 && !arready; n++) tick();
    tick();
    arvalid = 1'b0;
    chk("rd_rvalid", {31'd0, rvalid}, 32'd1);
    pop_rdata("rd_data");
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("rvalid_clr", {31'd0, rvalid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0; awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    wdata = '0; wstrb = '0;
    for (int i = 0; i < 4; i++) model[i] = 32'd0;

    // Reset state
    repeat (3) tick();
    chk("rst_awready", {31'd0, awready}, 32'd1);
    chk("rst_wready", {31'd0, wready}, 32'd1);
    chk("rst_arready", {31'd0, arready}, 32'd1);
    chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_pulse", {28'd0, reg_wr_pulse}, 32'd0);
    chk("rst_reg3", slv_reg3, 32'd0);
    aresetn = 1'b1;
    tick();

    // Sequential write then read
    for (int i = 0; i < 4; i++) axi_write(8'(4 * i), 32'(i + 1), 4'hF);
    for (int i = 0; i < 4; i++) axi_read(8'(4 * i));

    // Partial strobe
    axi_write(8'h04, 32'hAABBCCDD, 4'hF);
    axi_write(8'h04, 32'h11223344, 4'b0101);
    axi_read(8'h04);
    chk("strobe_reg1", slv_reg1, 32'hAA22CC44);

    // Address before data
    awaddr = 8'h08; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    for (int n = 0; n < 3; n++) begin
      chk("aw_wait_awready", {31'd0, awready}, 32'd0);
      chk("aw_wait_bvalid", {31'd0, bvalid}, 32'd0);
      tick();
    end
    wdata = 32'hDEAD0000; wstrb = 4'hF; wvalid = 1'b1;
    chk("aw_first_wready", {31'd0, wready}, 32'd1);
    tick();
    wvalid = 1'b0;
    model[2] = 32'hDEAD0000;
    chk("aw_first_bvalid", {31'd0, bvalid}, 32'd1);
    chk("aw_first_pulse", {28'd0, reg_wr_pulse}, 32'h4);
    chk("aw_first_reg2", slv_reg2, 32'hDEAD0000);
    bhandshake();

    // Data before address
    wdata = 32'h5; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    for (int n = 0; n < 2; n++) begin
      chk("w_wait_wready", {31'd0, wready}, 32'd0);
      chk("w_wait_awready", {31'd0, awready}, 32'd1);
      tick();
    end
    awaddr = 8'h0C; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    model[3] = 32'h5;
    chk("w_first_bvalid", {31'd0, bvalid}, 32'd1);
    chk("w_first_reg3", slv_reg3, 32'h5);
    bhandshake();

    // Simultaneous read and write of the same register
    awaddr = 8'h0C; wdata = 32'h99; wstrb = 4'hF; araddr = 8'h0C;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    exp_q.push_back(model[3]);
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    model[3] = 32'h99;
    chk("rw_same_rvalid", {31'd0, rvalid}, 32'd1);
    pop_rdata("rw_same_old");
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    axi_read(8'h0C);

    // Backpressure with aliased read (0x14 -> reg1)
    awaddr = 8'h00; wdata = 32'h7; wstrb = 4'hF; araddr = 8'h14;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    exp_q.push_back(model[1]);
    tick();
    model[0] = 32'h7;
    awaddr = 8'h04; wdata = 32'hFFFFFFFF; araddr = 8'h00;
    for (int n = 0; n < 10; n++) begin
      chk("bp_bvalid", {31'd0, bvalid}, 32'd1);
      chk("bp_rvalid", {31'd0, rvalid}, 32'd1);
      chk("bp_rdata", rdata, (exp_q.size() > 0) ? exp_q[0] : 32'hX);
      chk("bp_awready", {31'd0, awready}, 32'd0);
      chk("bp_arready", {31'd0, arready}, 32'd0);
      tick();
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    pop_rdata("alias_rd");
    chk("bp_reg1_kept", slv_reg1, model[1]);
    chk("bp_reg0", slv_reg0, 32'h7);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("bp_rvalid_clr", {31'd0, rvalid}, 32'd0);
    chk("bp_bvalid_hold", {31'd0, bvalid}, 32'd1);

    // Reset while a write response is pending
    aresetn = 1'b0;
    tick();
    chk("mid_rst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("mid_rst_reg0", slv_reg0, 32'd0);
    chk("mid_rst_reg1", slv_reg1, 32'd0);
    chk("mid_rst_reg2", slv_reg2, 32'd0);
    chk("mid_rst_reg3", slv_reg3, 32'd0);
    chk("mid_rst_awready", {31'd0, awready}, 32'd1);
    chk("mid_rst_wready", {31'd0, wready}, 32'd1);
    chk("mid_rst_arready", {31'd0, arready}, 32'd1);
    aresetn = 1'b1;
    for (int i = 0; i < 4; i++) model[i] = 32'd0;
    tick();
    axi_read(8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fnd_cntr_axil_slave.md
Name: fnd_cntr_axil_slave

Overview:
AXI4-Lite responder (slave) for the external FND counter IP. It is the S00_AXI endpoint that the bench's AXI VIP master drives. It holds four 32-bit read/write control registers, exposes them to the FND counter core, and emits a one-cycle write pulse per register so the core can react to register updates. One outstanding write and one outstanding read are supported, and the two channels run independently.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 4, byte address width; addr[3:2] selects the register.

Ports:
s00_axi_aclk  in  1  clock; all logic on rising edge
s00_axi_aresetn  in  1  reset, synchronous, active-low
s00_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address
s00_axi_awprot  in  3  ignored
s00_axi_awvalid / s00_axi_awready  in / out  1  AW handshake
s00_axi_wdata  in  32  write data
s00_axi_wstrb  in  4  byte enables
s00_axi_wvalid / s00_axi_wready  in / out  1  W handshake
s00_axi_bresp  out  2  always 2'b00 (OKAY)
s00_axi_bvalid / s00_axi_bready  out / in  1  B handshake
s00_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address
s00_axi_arprot  in  3  ignored
s00_axi_arvalid / s00_axi_arready  in / out  1  AR handshake
s00_axi_rdata  out  32  read data
s00_axi_rresp  out  2  always 2'b00
s00_axi_rvalid / s00_axi_rready  out / in  1  R handshake
slv_reg0..slv_reg3  out  32 each  register contents to the counter core
reg_wr_pulse  out  4  bit n high for 1 cycle when slv_regn is written

Behaviour:
- Reset (aresetn=0 sampled at edge):
  - slv_reg0..3 = 0; reg_wr_pulse = 0; bvalid = 0; rvalid = 0; rdata = 0.
  - awready = 1, wready = 1, arready = 1 during and after reset.
  - Both FSMs go to idle. Any in-flight transaction is dropped with no response.
- Write FSM states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
  - W_IDLE: awready = wready = 1.
    - AW and W handshake in the same cycle: commit the write at that edge, go to W_RESP.
    - Only AW handshakes: latch the address, go to W_HAVE_ADDR.
    - Only W handshakes: latch data and strobe, go to W_HAVE_DATA.
  - W_HAVE_ADDR: awready = 0, wready = 1. On W handshake, commit and go to W_RESP.
  - W_HAVE_DATA: wready = 0, awready = 1. On AW handshake, commit and go to W_RESP.
  - W_RESP: awready = wready = 0, bvalid = 1. On bready, go to W_IDLE.
  - Write latency: bvalid rises the cycle after the commit edge. Best case is 2 cycles from AW/W valid to B handshake.
- Commit:
  - Register index = addr[3:2].
  - For each byte b with wstrb[b] = 1, slv_reg[idx][8b+7:8b] = wdata byte b; other bytes are unchanged.
  - reg_wr_pulse[idx] = 1 for the cycle after the commit, even when wstrb = 0.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready = 1. On AR handshake, rdata <= slv_reg[araddr[3:2]] as sampled before that edge's write commit; rvalid = 1; go to R_DATA.
  - R_DATA: arready = 0; rdata and rvalid are held stable until rready. On rready, go to R_IDLE.
  - Read latency: rvalid rises the cycle after the AR handshake.
- Address handling: addr[1:0] and bits above [3:2] are ignored, so addresses alias modulo 16. No SLVERR or DECERR is ever returned.
- Simultaneous read and write of the same register in one edge: the read returns the old value, and the new value is visible to the next read.
- Backpressure: bvalid and rvalid stay asserted indefinitely while bready or rready is low. No new transaction is accepted on a channel until its response completes.

Decomposition:
- Package fnd_cntr_axil_pkg holds:
  - RESP_OKAY = 2'b00.
  - NUM_REGS = 4.
  - Register index localparams REG_CTRL = 0, REG_PRESET = 1, REG_CFG = 2, REG_AUX = 3.
  - Write and read FSM state enums.
- No sub-module is needed. The byte-strobe merge is a function in the package, apply_wstrb(old, wdata, wstrb).

Test Plan:
- Sequential write then read: write 1, 2, 3, 4 to 0x0/0x4/0x8/0xC, then read them back → rdata = 1, 2, 3, 4; bresp and rresp = 0; reg_wr_pulse = 0001, 0010, 0100, 1000 in turn.
- Partial strobe: reg1 = 0xAABBCCDD, then write 0x11223344 with wstrb = 4'b0101 → read gives 0xAA22CC44.
- Address before data: AW at 0x8, W 3 cycles later with 0xDEAD0000 → awready low while waiting, bvalid the cycle after W; slv_reg2 = 0xDEAD0000.
- Data before address: W 0x5, then AW 0xC 2 cycles later → wready low while waiting, slv_reg3 = 5.
- Backpressure: hold bready and rready low for 10 cycles → bvalid and rvalid stay high, rdata stays stable, and a second AW/AR is not accepted. Aliasing: a read at 0x14 returns slv_reg1.
- Reset mid-operation: deassert aresetn while bvalid = 1 with reg0 = 0x7 → next cycle bvalid = 0, all registers = 0, and awready, wready, arready = 1.
